// File: rtl/pic_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pic_ack_sequencer
// Description : Interrupt-acknowledge and in-service controller for an
//               8259-style PIC. Resolves rotating priority over the eight IR
//               lines, owns the in-service register and rotation pointer,
//               raises INT, runs the two-pulse 8086 INTA sequence and emits
//               the vector byte. Applies EOI / auto-EOI / rotation.
// Ports       :
//   clk, rst          - clock, synchronous active-high reset
//   irr, imr          - request and mask registers
//   vbase             - vector base T7..T3
//   aeoi, rot_en      - auto-EOI mode, rotate on EOI/AEOI
//   inta_pulse        - one strobe per INTA falling edge
//   eoi_cmd, eoi_specific, eoi_level - OCW2 EOI command
//   int_out           - interrupt request to CPU
//   vec_out/vec_valid - vector byte and its one-cycle qualifier
//   ack_clr           - one-hot clear of the acknowledged IRR bit
//   isr, prio_ptr     - in-service register, lowest-priority level
//   spurious          - acknowledge found no request
// Revision    : 1.0 - initial release
// ============================================================================
module pic_ack_sequencer #(
    parameter logic [2:0] RESET_PTR = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] vbase,
    input  logic       aeoi,
    input  logic       rot_en,
    input  logic       inta_pulse,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] vec_out,
    output logic       vec_valid,
    output logic [7:0] ack_clr,
    output logic [7:0] isr,
    output logic [2:0] prio_ptr,
    output logic       spurious
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_lvl;       // level latched on the first INTA pulse
    logic       r_lvl_spur;  // the latched level came from a spurious ack

    logic [7:0] w_pending;
    logic       w_cand_found;
    logic [2:0] w_cand;
    logic       w_hi_found;
    logic [2:0] w_hi;
    logic       w_cand_ok;
    logic [7:0] w_set;
    logic [7:0] w_aeoi_clr;
    logic       w_aeoi_rot;
    logic [7:0] w_eoi_clr;
    logic       w_eoi_rot;
    logic [2:0] w_eoi_ptr;

    // Highest-priority set bit of v: scan from the lowest priority upward so
    // the last hit (k=0, just after ptr) wins. Returns {found, level}.
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = ptr + 3'(k + 1);
            if (v[lvl]) begin
                res = {1'b1, lvl};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_pending                  = irr & ~imr;
        {w_cand_found, w_cand}     = pick(w_pending, prio_ptr);
        {w_hi_found, w_hi}         = pick(isr, prio_ptr);
        // Rank = distance from the top-priority slot; smaller ranks win.
        w_cand_ok = w_cand_found &&
                    (!w_hi_found || ((w_cand - prio_ptr - 3'd1) < (w_hi - prio_ptr - 3'd1)));

        w_set = 8'd0;
        if (r_state == REQ && inta_pulse && w_cand_found) begin
            w_set = 8'd1 << w_cand;
        end

        w_aeoi_clr = 8'd0;
        w_aeoi_rot = 1'b0;
        if (r_state == ACK1 && inta_pulse && aeoi && !r_lvl_spur) begin
            w_aeoi_clr = 8'd1 << r_lvl;
            w_aeoi_rot = rot_en;
        end

        // Non-specific EOI picks its level from the ISR as it stood before
        // this cycle's update.
        w_eoi_clr = 8'd0;
        w_eoi_rot = 1'b0;
        w_eoi_ptr = prio_ptr;
        if (eoi_cmd) begin
            if (eoi_specific) begin
                w_eoi_clr = 8'd1 << eoi_level;
                w_eoi_rot = rot_en;
                w_eoi_ptr = eoi_level;
            end else if (w_hi_found) begin
                w_eoi_clr = 8'd1 << w_hi;
                w_eoi_rot = rot_en;
                w_eoi_ptr = w_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lvl      <= 3'd7;
            r_lvl_spur <= 1'b0;
            int_out    <= 1'b0;
            vec_out    <= 8'd0;
            vec_valid  <= 1'b0;
            ack_clr    <= 8'd0;
            isr        <= 8'd0;
            prio_ptr   <= RESET_PTR;
            spurious   <= 1'b0;
        end else begin
            vec_valid <= 1'b0;
            ack_clr   <= 8'd0;
            spurious  <= 1'b0;

            // Setting a bit beats any clear of the same bit in this cycle.
            isr <= (isr & ~w_eoi_clr & ~w_aeoi_clr) | w_set;

            // AEOI rotation takes precedence over EOI rotation.
            if (w_aeoi_rot) begin
                prio_ptr <= r_lvl;
            end else if (w_eoi_rot) begin
                prio_ptr <= w_eoi_ptr;
            end

            case (r_state)
                IDLE: begin
                    if (w_cand_ok) begin
                        int_out <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (inta_pulse) begin
                        int_out <= 1'b0;
                        r_state <= ACK1;
                        if (w_cand_found) begin
                            r_lvl      <= w_cand;
                            r_lvl_spur <= 1'b0;
                            ack_clr    <= w_set;
                        end else begin
                            r_lvl      <= 3'd7;
                            r_lvl_spur <= 1'b1;
                            spurious   <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta_pulse) begin
                        vec_out   <= {vbase, r_lvl};
                        vec_valid <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
